fft8_seq: RTL and testbench

Frame sequencer for the 8-point FFT core. It accepts a stream of 8 complex samples and writes them into the core's input RAM in load order. It then starts the core and waits for completion under a watchdog. Finally it drains the 8 results from the result RAM onto a backpressured output stream. It sits between the system stream interface and the FFT core/AGU.

---
 rtl/fft8_seq.sv | 196 +++++++++++++++++++
 tb/tb_fft8_seq.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_seq.sv
// fft8_seq: frame sequencer for the 8-point FFT core.
// Loads 8 input samples into the core input RAM, starts the core under a
// down-counting watchdog, then drains the 8 results in natural order onto
// a backpressured output stream through a 2-entry FIFO.
// Build option: define FFT8_SEQ_BITREV_EN to store input samples at
// bit-reversed addresses (decimation-in-time order); otherwise the input
// RAM is written in natural order and the core reorders internally.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | accept input samples, write them to the input RAM
// ST_KICK  | one-cycle core_start pulse, arm the watchdog
// ST_RUN   | wait for core_done; abort the frame when the watchdog expires
// ST_DRAIN | read result RAM 0..7 into the output FIFO until out_last leaves
module fft8_seq #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    output logic                    load_we,
    output logic [2:0]              load_addr,
    output logic [2*DATA_WIDTH-1:0] load_data,
    output logic                    core_start,
    input  logic                    core_done,
    input  logic                    core_mem_sel,
    output logic                    rd_en,
    output logic [2:0]              rd_addr,
    output logic                    rd_mem_sel,
    input  logic [2*DATA_WIDTH-1:0] rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    err_timeout,
    output logic [15:0]             frame_cnt
);
    localparam int SW   = 2 * DATA_WIDTH;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_LOAD, ST_KICK, ST_RUN, ST_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [2:0]      load_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic [3:0]      rd_cnt;
    logic            inflight, inflight_last;
    logic [1:0]      occ;
    logic [SW-1:0]   slot0, slot1;
    logic            last0, last1;
    logic            accept, done_hs, fifo_pop, fifo_push;

    function automatic logic [2:0] addr_map(input logic [2:0] n);
`ifdef FFT8_SEQ_BITREV_EN
        return {n[0], n[1], n[2]};
`else
        return n;
`endif
    endfunction

    // Head of the FIFO, or the returning read data directly when the FIFO is
    // empty so a result reaches the output in the cycle it comes back.
    assign out_valid = (occ != 2'd0) || inflight;
    assign out_data  = (occ != 2'd0) ? slot0 : (inflight ? rd_data : '0);
    assign out_last  = (occ != 2'd0) ? last0 : (inflight && inflight_last);
    assign rd_addr   = rd_cnt[2:0];
    assign busy      = (state != ST_LOAD) || (load_cnt != 3'd0);
    assign accept    = in_valid && in_ready;
    assign done_hs   = out_valid && out_ready && out_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_nxt;
    end

    // Next-state decode and per-state handshake/strobe outputs.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        rd_en      = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = !rst;
                if (in_valid && !rst && (load_cnt == 3'd7)) state_nxt = ST_KICK;
            end
            ST_KICK: begin
                core_start = 1'b1;
                state_nxt  = ST_RUN;
            end
            ST_RUN: begin
                // core_done takes priority over a watchdog expiry in the same cycle
                if (core_done)             state_nxt = ST_DRAIN;
                else if (wd_cnt == '0)     state_nxt = ST_LOAD;
            end
            ST_DRAIN: begin
                rd_en = (rd_cnt < 4'd8) && (({1'b0, occ} + {2'b00, inflight}) < 3'd2);
                if (done_hs) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Load path, watchdog, read sequencing and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt      <= 3'd0;
            load_we       <= 1'b0;
            load_addr     <= 3'd0;
            load_data     <= '0;
            wd_cnt        <= '0;
            rd_cnt        <= 4'd0;
            rd_mem_sel    <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            err_timeout   <= 1'b0;
            frame_cnt     <= 16'd0;
        end else begin
            load_we <= accept;
            if (accept) begin
                load_addr <= addr_map(load_cnt);
                load_data <= in_data;
                load_cnt  <= load_cnt + 3'd1;
            end
            if (state == ST_KICK) begin
                wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
            end else if (state == ST_RUN) begin
                if (core_done) begin
                    rd_mem_sel <= core_mem_sel;
                    rd_cnt     <= 4'd0;
                end else if (wd_cnt == '0) begin
                    err_timeout <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt - WD_W'(1);
                end
            end
            inflight      <= rd_en;
            inflight_last <= rd_en && (rd_cnt == 4'd7);
            if (rd_en) rd_cnt <= rd_cnt + 4'd1;
            if (done_hs) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // FIFO control: a returning read bypasses the FIFO when it is empty and
    // the sink is ready; otherwise it is parked behind any held entry.
    always_comb begin
        fifo_pop  = (occ != 2'd0) && out_ready;
        fifo_push = inflight && !((occ == 2'd0) && out_ready);
    end

    // Two-entry output FIFO storage; slot0 is always the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            case ({fifo_pop, fifo_push})
                2'b10: begin
                    slot0 <= slot1;
                    last0 <= last1;
                    occ   <= occ - 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd0) begin
                        slot0 <= rd_data;
                        last0 <= inflight_last;
                    end else begin
                        slot1 <= rd_data;
                        last1 <= inflight_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        slot0 <= rd_data;
                        last0 <= inflight_last;
                    end else begin
                        slot0 <= slot1;
                        last0 <= last1;
                        slot1 <= rd_data;
                        last1 <= inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fft8_seq.sv
// Directed bench for fft8_seq: load addressing, start timing, drain under
// backpressure, watchdog boundary and expiry, stray core_done, and reset
// in the middle of a drain.
module tb_fft8_seq;
    localparam int DW = 32;
    localparam int SW = 2 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_data = '0;
    logic          load_we;
    logic [2:0]    load_addr;
    logic [SW-1:0] load_data;
    logic          core_start;
    logic          core_done = 1'b0;
    logic          core_mem_sel = 1'b0;
    logic          rd_en;
    logic [2:0]    rd_addr;
    logic          rd_mem_sel;
    logic [SW-1:0] rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [SW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          err_timeout;
    logic [15:0]   frame_cnt;

    fft8_seq #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .core_start(core_start), .core_done(core_done), .core_mem_sel(core_mem_sel),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_mem_sel(rd_mem_sel), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_timeout(err_timeout), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int tag = 0;
    logic [2:0] map_tbl [8];

    logic [2:0]    wr_addr_q[$];
    logic [SW-1:0] wr_data_q[$];
    logic [SW:0]   out_q[$];
    int first_acc_cyc = -1, last_acc_cyc = -1, first_wr_cyc = -1;
    int start_cyc = -1, first_ov_cyc = -1, last_out_cyc = -1;
    int n_start = 0, rd_issued = 0, outs_acc = 0, max_fly = 0, unstable = 0;
    bit hold_pend = 1'b0;
    logic [SW:0] held = '0;

    // Result RAM model: tagged per frame, address and bank visible in the data.
    always @(posedge clk)
        if (rd_en) rd_data <= {32'hD000_0000 + 32'(tag) * 32'd16 + 32'(rd_addr), 31'h0, rd_mem_sel};

    // Event monitor, sampling pre-edge values.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
        end
        if (load_we) begin
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            wr_addr_q.push_back(load_addr);
            wr_data_q.push_back(load_data);
        end
        if (core_start) begin
            start_cyc = cyc;
            n_start++;
        end
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (rd_en) rd_issued++;
        if (rd_issued - outs_acc > max_fly) max_fly = rd_issued - outs_acc;
        if (out_valid && out_ready) begin
            out_q.push_back({out_last, out_data});
            outs_acc++;
            if (out_last) last_out_cyc = cyc;
        end
        if (hold_pend && (!out_valid || {out_last, out_data} !== held)) unstable++;
        hold_pend = out_valid && !out_ready && !rst;
        held = {out_last, out_data};
        if (rst) begin
            rd_issued = 0;
            outs_acc  = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        first_acc_cyc = -1;
        first_wr_cyc  = -1;
        first_ov_cyc  = -1;
        wr_addr_q.delete();
        wr_data_q.delete();
        out_q.delete();
    endtask

    task automatic send_frame(input logic [SW-1:0] base);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = base + SW'(i);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_start(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (core_start) ok = 1'b1;
            else tick();
        end
        chk({name, "_start_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic pulse_done(input int delay, input logic sel);
        repeat (delay) tick();
        core_done    = 1'b1;
        core_mem_sel = sel;
        tick();
        core_done    = 1'b0;
        core_mem_sel = 1'b0;
    endtask

    task automatic drain(input logic [3:0] pat);
        for (int c = 0; c < 60 && out_q.size() < 8; c++) begin
            out_ready = pat[c % 4];
            tick();
        end
        out_ready = 1'b1;
    endtask

    task automatic check_outputs(input string name, input int ftag, input logic sel);
        chk({name, "_out_count"}, 64'(out_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            chk({name, "_out_data"}, out_q[i][SW-1:0],
                {32'hD000_0000 + 32'(ftag) * 32'd16 + 32'(i), 31'h0, sel});
            chk({name, "_out_last"}, 64'(out_q[i][SW]), 64'(i == 7));
        end
    endtask

    task automatic check_loads(input string name, input logic [SW-1:0] base);
        chk({name, "_wr_count"}, 64'(wr_addr_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
            chk({name, "_load_addr"}, 64'(wr_addr_q[i]), 64'(map_tbl[i]));
            chk({name, "_load_data"}, wr_data_q[i], base + SW'(i));
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_in_ready"},    64'(in_ready),    64'd0);
        chk({p, "_load_we"},     64'(load_we),     64'd0);
        chk({p, "_load_addr"},   64'(load_addr),   64'd0);
        chk({p, "_load_data"},   load_data,        64'd0);
        chk({p, "_core_start"},  64'(core_start),  64'd0);
        chk({p, "_rd_en"},       64'(rd_en),       64'd0);
        chk({p, "_rd_addr"},     64'(rd_addr),     64'd0);
        chk({p, "_rd_mem_sel"},  64'(rd_mem_sel),  64'd0);
        chk({p, "_out_valid"},   64'(out_valid),   64'd0);
        chk({p, "_out_data"},    out_data,         64'd0);
        chk({p, "_out_last"},    64'(out_last),    64'd0);
        chk({p, "_busy"},        64'(busy),        64'd0);
        chk({p, "_err_timeout"}, 64'(err_timeout), 64'd0);
        chk({p, "_frame_cnt"},   64'(frame_cnt),   64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int snap_start;
        int snap_rd;
`ifdef FFT8_SEQ_BITREV_EN
        map_tbl = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
`else
        map_tbl = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
        // Reset values while rst is held.
        repeat (3) tick();
        @(negedge clk);
        chk_reset("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        tick();

        // Frame 1: back-to-back load, core_done 10 cycles after start, bank 1.
        tag = 1;
        clear_frame();
        send_frame(64'h1);
        wait_start("f1");
        chk("f1_busy_kick", 64'(busy), 64'd1);
        chk("f1_in_ready_kick", 64'(in_ready), 64'd0);
        pulse_done(10, 1'b1);
        drain(4'b1111);
        @(negedge clk);
        check_loads("f1", 64'h1);
        chk("f1_wr_latency", 64'(first_wr_cyc - first_acc_cyc), 64'd1);
        chk("f1_start_latency", 64'(start_cyc - last_acc_cyc), 64'd1);
        chk("f1_first_out_latency", 64'(first_ov_cyc - last_acc_cyc), 64'd13);
        chk("f1_drain_end", 64'(last_out_cyc - start_cyc), 64'd19);
        check_outputs("f1", 1, 1'b1);
        chk("f1_rd_mem_sel", 64'(rd_mem_sel), 64'd1);
        chk("f1_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("f1_idle_in_ready", 64'(in_ready), 64'd1);
        chk("f1_idle_busy", 64'(busy), 64'd0);
        tick();

        // Frame 2: drain with out_ready 1,0,0,1 repeating.
        tag = 2;
        clear_frame();
        unstable = 0;
        max_fly  = 0;
        send_frame(64'h100);
        wait_start("f2");
        pulse_done(3, 1'b0);
        drain(4'b1001);
        @(negedge clk);
        check_loads("f2", 64'h100);
        check_outputs("f2", 2, 1'b0);
        chk("f2_stable_while_stalled", 64'(unstable), 64'd0);
        chk("f2_inflight_le2", 64'(max_fly <= 2), 64'd1);
        chk("f2_frame_cnt", 64'(frame_cnt), 64'd2);
        tick();

        // Frame 3: core_done in the 64th watchdog cycle still wins.
        tag = 3;
        clear_frame();
        send_frame(64'h200);
        wait_start("f3");
        pulse_done(64, 1'b1);
        drain(4'b1111);
        @(negedge clk);
        check_outputs("f3", 3, 1'b1);
        chk("f3_err_timeout", 64'(err_timeout), 64'd0);
        chk("f3_frame_cnt", 64'(frame_cnt), 64'd3);
        tick();

        // Frame 4: no core_done, watchdog expires after 64 cycles.
        tag = 4;
        clear_frame();
        snap_rd = rd_issued;
        send_frame(64'h300);
        wait_start("f4");
        repeat (64) tick();
        @(negedge clk);
        chk("f4_err_not_early", 64'(err_timeout), 64'd0);
        chk("f4_busy_in_run", 64'(busy), 64'd1);
        tick();
        @(negedge clk);
        chk("f4_err_timeout", 64'(err_timeout), 64'd1);
        chk("f4_in_ready", 64'(in_ready), 64'd1);
        chk("f4_frame_cnt", 64'(frame_cnt), 64'd3);
        chk("f4_no_reads", 64'(rd_issued - snap_rd), 64'd0);
        tick();

        // Frame 5: normal frame after the abort; error flag stays sticky.
        tag = 5;
        clear_frame();
        send_frame(64'h400);
        wait_start("f5");
        pulse_done(5, 1'b0);
        drain(4'b1111);
        @(negedge clk);
        check_outputs("f5", 5, 1'b0);
        chk("f5_frame_cnt", 64'(frame_cnt), 64'd4);
        chk("f5_err_sticky", 64'(err_timeout), 64'd1);
        tick();

        // Stray core_done while loading is ignored.
        snap_rd = rd_issued;
        core_done    = 1'b1;
        core_mem_sel = 1'b1;
        tick();
        core_done    = 1'b0;
        core_mem_sel = 1'b0;
        tick();
        @(negedge clk);
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_out_valid", 64'(out_valid), 64'd0);
        chk("stray_no_reads", 64'(rd_issued - snap_rd), 64'd0);
        tick();
        tag = 6;
        clear_frame();
        send_frame(64'h500);
        wait_start("f6");
        pulse_done(2, 1'b0);
        drain(4'b1111);
        @(negedge clk);
        check_outputs("f6", 6, 1'b0);
        chk("f6_rd_mem_sel", 64'(rd_mem_sel), 64'd0);
        chk("f6_frame_cnt", 64'(frame_cnt), 64'd5);
        tick();

        // Frame 7: reset after 3 outputs of the drain.
        tag = 7;
        clear_frame();
        send_frame(64'h600);
        wait_start("f7");
        pulse_done(4, 1'b1);
        out_ready = 1'b1;
        for (int c = 0; c < 30 && out_q.size() < 3; c++) tick();
        chk("f7_outputs_before_rst", 64'(out_q.size()), 64'd3);
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        @(negedge clk);
        chk_reset("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        snap_start = n_start;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (4) tick();
        @(negedge clk);
        chk("midrst_no_start", 64'(n_start - snap_start), 64'd0);
        chk("midrst_no_reads", 64'(rd_issued), 64'd0);
        tick();

        // Frame 8: clean frame after reset loads from address 0.
        tag = 8;
        clear_frame();
        send_frame(64'h700);
        wait_start("f8");
        pulse_done(3, 1'b0);
        drain(4'b1111);
        @(negedge clk);
        check_loads("f8", 64'h700);
        check_outputs("f8", 8, 1'b0);
        chk("f8_frame_cnt", 64'(frame_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
